lcd_write_engine: RTL

//  Nios II multicycle custom instruction that performs one HD44780 bus write (command or

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_delay_counter.sv | 29 ++
 rtl/lcd_write_engine.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions: write-engine state encoding, command bytes and
// default bus timing at 50 MHz, common to the initializer and the write engine.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_HOME      = 8'h02;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;

    localparam int unsigned LCD_T_SETUP_CYC = 4;
    localparam int unsigned LCD_T_EN_CYC    = 25;
    localparam int unsigned LCD_T_HOLD_CYC  = 4;
    localparam int unsigned LCD_T_EXEC_CYC  = 2000;
    localparam int unsigned LCD_T_LONG_CYC  = 82000;
    localparam int unsigned LCD_CNT_W       = 17;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] cmd);
        return (!rs) && (cmd[7:2] == 6'b0) && (cmd != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down counter for LCD phase timing; saturates at zero instead of wrapping.
module lcd_delay_counter
    import lcd_pkg::*;
#(
    parameter int unsigned CNT_W = LCD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// Nios II multicycle custom instruction: one HD44780 write (setup, E pulse, hold)
// followed by the controller execution wait, signalled by a one-cycle done.
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = LCD_T_SETUP_CYC,
    parameter int unsigned T_EN_CYC    = LCD_T_EN_CYC,
    parameter int unsigned T_HOLD_CYC  = LCD_T_HOLD_CYC,
    parameter int unsigned T_EXEC_CYC  = LCD_T_EXEC_CYC,
    parameter int unsigned T_LONG_CYC  = LCD_T_LONG_CYC,
    parameter int unsigned CNT_W       = LCD_CNT_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        lcd_enable,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);

    lcd_state_e       state, state_nxt;
    logic             long_wait, long_wait_nxt;
    logic             enable_nxt, done_nxt, rs_nxt;
    logic [7:0]       data_nxt;
    logic [31:0]      result_nxt;
    logic             cnt_load_req;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             unused_bits;

    assign unused_bits = ^{dataa[31:9], datab[31:1]};

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (clk_en && cnt_load_req),
        .load_val (cnt_val),
        .en       (clk_en),
        .zero     (cnt_zero)
    );

    // State and registered outputs; clk_en low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            long_wait  <= 1'b0;
            lcd_enable <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_data   <= 8'h00;
            done       <= 1'b0;
            result     <= 32'h0;
        end else if (clk_en) begin
            state      <= state_nxt;
            long_wait  <= long_wait_nxt;
            lcd_enable <= enable_nxt;
            lcd_rs     <= rs_nxt;
            lcd_rw     <= 1'b0;
            lcd_data   <= data_nxt;
            done       <= done_nxt;
            result     <= result_nxt;
        end
    end

    // Next-state and next-output decode; each phase ends when the counter reaches zero.
    always_comb begin
        state_nxt     = state;
        long_wait_nxt = long_wait;
        enable_nxt    = lcd_enable;
        rs_nxt        = lcd_rs;
        data_nxt      = lcd_data;
        done_nxt      = done;
        result_nxt    = result;
        cnt_load_req  = 1'b0;
        cnt_val       = '0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    data_nxt      = dataa[7:0];
                    rs_nxt        = dataa[8];
                    result_nxt    = {23'b0, dataa[8:0]};
                    long_wait_nxt = datab[0] | is_long_cmd(dataa[8], dataa[7:0]);
                    cnt_load_req  = 1'b1;
                    cnt_val       = LD_SETUP;
                    state_nxt     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    enable_nxt   = 1'b1;
                    cnt_load_req = 1'b1;
                    cnt_val      = LD_EN;
                    state_nxt    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt_zero) begin
                    enable_nxt   = 1'b0;
                    cnt_load_req = 1'b1;
                    cnt_val      = LD_HOLD;
                    state_nxt    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    cnt_load_req = 1'b1;
                    cnt_val      = long_wait ? LD_LONG : LD_EXEC;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
